mem_port_arbiter: RTL and testbench

Shares the single external memory port between the instruction-cache read channel, the data-cache read channel and the data-cache write channel. It sits between the core's three cache memory interfaces and the memory controller. It arbitrates whole burst transactions, sequences address issue and data beats, and routes returned read data to the owning requester. An optional starvation guard bounds instruction-fetch latency under heavy data traffic.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_priority.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owners
// and the fixed arbitration order (highest first).
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RDATA, WDATA} arb_state_e;
   typedef enum logic [1:0] {OWN_IR, OWN_DR, OWN_DW} arb_owner_e;

   // Write first so a dirty eviction reaches memory before its refill read.
   localparam arb_owner_e PRIO_HI  = OWN_DW;
   localparam arb_owner_e PRIO_MID = OWN_DR;
   localparam arb_owner_e PRIO_LO  = OWN_IR;

   function automatic logic [2:0] owner_onehot(input arb_owner_e owner);
      logic [2:0] v;
      v = '0;
      v[owner] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational winner select for the memory port; with MEM_ARB_STARVE_GUARD_EN
// defined it also tracks D-side grants made while the I-side waits.
module mem_arb_priority
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 8
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_ir_req,
   input  logic       i_dr_req,
   input  logic       i_dw_req,
   input  logic       i_idle,
   output arb_owner_e o_win,
   output logic       o_win_valid
);

   // Bit position equals the owner encoding.
   logic [2:0] w_req;
   logic       w_starved;

   assign w_req = {i_dw_req, i_dr_req, i_ir_req};

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [SW-1:0] r_starve_cnt;

   assign w_starved = i_ir_req && (r_starve_cnt == STARVE_LIM);

   // In IDLE with ir pending a winner always exists, so a non-ir winner is a D grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (i_idle) begin
         if (!i_ir_req || o_win == OWN_IR)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != STARVE_LIM)
            r_starve_cnt <= r_starve_cnt + SW'(1);
      end
   end
`else
   logic w_unused;
   assign w_unused  = ^{clk, rst_n, i_idle};
   assign w_starved = 1'b0;
`endif

   always_comb begin
      o_win_valid = |w_req;
      if (w_starved)           o_win = OWN_IR;
      else if (w_req[PRIO_HI])  o_win = PRIO_HI;
      else if (w_req[PRIO_MID]) o_win = PRIO_MID;
      else                      o_win = PRIO_LO;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one burst memory port between I-read, D-read and D-write channels.
// MEM_ARB_STARVE_GUARD_EN enables the instruction-fetch starvation guard.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 26,
   parameter int DATA_W     = 32,
   parameter int BURST_LEN  = 4,
   parameter int STARVE_MAX = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ir_req,
   input  logic              dr_req,
   input  logic              dw_req,
   input  logic [ADDR_W-1:0] ir_addr,
   input  logic [ADDR_W-1:0] dr_addr,
   input  logic [ADDR_W-1:0] dw_addr,
   output logic              ir_gnt,
   output logic              dr_gnt,
   output logic              dw_gnt,
   output logic              ir_rvalid,
   output logic              dr_rvalid,
   output logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] dw_wdata,
   output logic              dw_wready,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   input  logic              m_ack,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_wready,
   output logic [DATA_W-1:0] m_wdata,
   output arb_state_e        o_dbg_state
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

   arb_state_e        r_state;
   arb_owner_e        r_owner;
   logic [BW-1:0]     r_beat_cnt;
   logic              r_ir_gnt, r_dr_gnt, r_dw_gnt;
   logic              r_m_req, r_m_we;
   logic [ADDR_W-1:0] r_m_addr;

   arb_owner_e        w_win;
   logic              w_win_valid;
   logic [ADDR_W-1:0] w_win_addr;
   logic              w_rd_beat;
   logic              w_wr_beat;
   logic              w_last;

   mem_arb_priority #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_ir_req    (ir_req),
      .i_dr_req    (dr_req),
      .i_dw_req    (dw_req),
      .i_idle      (r_state == IDLE),
      .o_win       (w_win),
      .o_win_valid (w_win_valid)
   );

   always_comb begin
      case (w_win)
         OWN_DW:  w_win_addr = dw_addr;
         OWN_DR:  w_win_addr = dr_addr;
         default: w_win_addr = ir_addr;
      endcase
   end

   // Handshakes: req is held until its one-cycle gnt; m_req is held until m_ack;
   // a data beat moves only in the cycle m_rvalid (read) or m_wready (write) is high.
   assign w_rd_beat = (r_state == RDATA) && m_rvalid;
   assign w_wr_beat = (r_state == WDATA) && m_wready;
   assign w_last    = (r_beat_cnt == LAST_BEAT);

   assign ir_rvalid   = w_rd_beat && (r_owner == OWN_IR);
   assign dr_rvalid   = w_rd_beat && (r_owner == OWN_DR);
   assign rdata       = w_rd_beat ? m_rdata : '0;
   assign dw_wready   = w_wr_beat;
   assign m_wdata     = dw_wdata;
   assign ir_gnt      = r_ir_gnt;
   assign dr_gnt      = r_dr_gnt;
   assign dw_gnt      = r_dw_gnt;
   assign m_req       = r_m_req;
   assign m_we        = r_m_we;
   assign m_addr      = r_m_addr;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_owner    <= OWN_IR;
         r_beat_cnt <= '0;
         r_ir_gnt   <= 1'b0;
         r_dr_gnt   <= 1'b0;
         r_dw_gnt   <= 1'b0;
         r_m_req    <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_addr   <= '0;
      end else begin
         {r_dw_gnt, r_dr_gnt, r_ir_gnt} <= 3'b000;
         case (r_state)
            IDLE: begin
               if (w_win_valid) begin
                  r_owner                        <= w_win;
                  r_m_addr                       <= w_win_addr;
                  r_m_we                         <= (w_win == OWN_DW);
                  r_m_req                        <= 1'b1;
                  {r_dw_gnt, r_dr_gnt, r_ir_gnt} <= owner_onehot(w_win);
                  r_state                        <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ack) begin
                  r_m_req    <= 1'b0;
                  r_beat_cnt <= '0;
                  r_state    <= r_m_we ? WDATA : RDATA;
               end
            end
            RDATA: begin
               if (w_rd_beat) begin
                  r_beat_cnt <= r_beat_cnt + BW'(1);
                  if (w_last) r_state <= IDLE;
               end
            end
            WDATA: begin
               if (w_wr_beat) begin
                  r_beat_cnt <= r_beat_cnt + BW'(1);
                  if (w_last) r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter; expectations depend on
// whether MEM_ARB_STARVE_GUARD_EN is defined for the build.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int BL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ir_req = 0, dr_req = 0, dw_req = 0;
   logic [25:0] ir_addr = '0, dr_addr = '0, dw_addr = '0;
   logic        ir_gnt, dr_gnt, dw_gnt, ir_rvalid, dr_rvalid, dw_wready;
   logic [31:0] rdata, m_wdata;
   logic [31:0] dw_wdata = '0;
   logic        m_req, m_we;
   logic [25:0] m_addr;
   logic        m_ack = 0, m_rvalid = 0, m_wready = 0;
   logic [31:0] m_rdata = '0;
   arb_state_e  dbg_state;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [62:0] exp_gnt_q[$];
   logic [33:0] exp_rd_q[$];
   logic [31:0] exp_wr_q[$];

   mem_port_arbiter #(.ADDR_W(26), .DATA_W(32), .BURST_LEN(BL), .STARVE_MAX(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ir_req(ir_req), .dr_req(dr_req), .dw_req(dw_req),
      .ir_addr(ir_addr), .dr_addr(dr_addr), .dw_addr(dw_addr),
      .ir_gnt(ir_gnt), .dr_gnt(dr_gnt), .dw_gnt(dw_gnt),
      .ir_rvalid(ir_rvalid), .dr_rvalid(dr_rvalid), .rdata(rdata),
      .dw_wdata(dw_wdata), .dw_wready(dw_wready),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_ack(m_ack),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_wready(m_wready),
      .m_wdata(m_wdata), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [62:0] gnt_rec(input int unsigned c, input logic [2:0] g,
                                           input logic [25:0] a, input logic we);
      return {32'(c), g, 1'b1, a, we};
   endfunction

   function automatic logic gnt_of(input int who);
      return (who == 0) ? ir_gnt : (who == 1) ? dr_gnt : dw_gnt;
   endfunction

   task automatic rst_checks(input string tag);
      chk({tag, "_ctl"}, 64'({ir_gnt, dr_gnt, dw_gnt, ir_rvalid, dr_rvalid, dw_wready, m_req, m_we}), 64'd0);
      chk({tag, "_addr"}, 64'(m_addr), 64'd0);
      chk({tag, "_rdata"}, 64'(rdata), 64'd0);
      chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
   endtask

   // ---------------- driver tasks ----------------
   // who: 0 = ir, 1 = dr, 2 = dw. Holds the request until its grant.
   task automatic do_req(input int who, input logic [25:0] a);
      int t = 0;
      case (who)
         0:       begin ir_addr = a; ir_req = 1; end
         1:       begin dr_addr = a; dr_req = 1; end
         default: begin dw_addr = a; dw_req = 1; end
      endcase
      @(negedge clk);
      while (!gnt_of(who) && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("gnt_seen", 64'(gnt_of(who)), 64'd1);
      case (who)
         0:       ir_req = 0;
         1:       dr_req = 0;
         default: dw_req = 0;
      endcase
   endtask

   // Memory side plus the write beat source: ack after ack_dly cycles, then
   // return BL read beats back-to-back or accept write beats per pat bits.
   task automatic mem_serve(input int ack_dly, input logic [31:0] base, input logic [15:0] pat);
      int t = 0;
      int acc = 0;
      int c = 0;
      while (!m_req && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("m_req_seen", 64'(m_req), 64'd1);
      if (m_req) begin
         repeat (ack_dly) @(negedge clk);
         m_ack = 1;
         @(negedge clk);
         m_ack = 0;
         if (m_we) begin
            while (acc < BL && c < 16) begin
               dw_wdata = base + 32'(acc);
               m_wready = pat[c];
               if (pat[c]) acc++;
               c++;
               @(negedge clk);
            end
            m_wready = 0;
            chk("w_beats_done", 64'(acc), 64'(BL));
         end else begin
            for (int i = 0; i < BL; i++) begin
               m_rvalid = 1;
               m_rdata  = base + 32'(i);
               @(negedge clk);
            end
            m_rvalid = 0;
         end
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always begin
      @(negedge clk);
      #2;
      if (ir_gnt || dr_gnt || dw_gnt) begin
         if (exp_gnt_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL gnt_unexpected: got %b expected none at %0t", {dw_gnt, dr_gnt, ir_gnt}, $time);
         end else
            chk("gnt", 64'({32'(cyc), dw_gnt, dr_gnt, ir_gnt, m_req, m_addr, m_we}), 64'(exp_gnt_q.pop_front()));
      end
      if (ir_rvalid || dr_rvalid) begin
         if (exp_rd_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_unexpected: got %b/%h expected none at %0t", {ir_rvalid, dr_rvalid}, rdata, $time);
         end else
            chk("rd_beat", 64'({ir_rvalid, dr_rvalid, rdata}), 64'(exp_rd_q.pop_front()));
      end
      if (dw_wready) begin
         if (exp_wr_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_unexpected: got %h expected none at %0t", m_wdata, $time);
         end else
            chk("wr_beat", 64'(m_wdata), 64'(exp_wr_q.pop_front()));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int unsigned c0;
      int unsigned c1;
      int          own[4];
      logic [25:0] adr[4];

      repeat (2) @(negedge clk);
      #1;
      rst_checks("reset");
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // Single ir read, ack two cycles after m_req.
      c0 = cyc;
      exp_gnt_q.push_back(gnt_rec(c0 + 1, 3'b001, 26'h100, 1'b0));
      for (int i = 0; i < BL; i++) exp_rd_q.push_back({2'b10, 32'hA0 + 32'(i)});
      fork
         do_req(0, 26'h100);
         mem_serve(2, 32'hA0, 16'hFFFF);
      join
      repeat (2) @(negedge clk);

      // dw and dr together: write first, one idle cycle, then the read.
      c0 = cyc;
      exp_gnt_q.push_back(gnt_rec(c0 + 1, 3'b100, 26'h180, 1'b1));
      exp_gnt_q.push_back(gnt_rec(c0 + 7, 3'b010, 26'h280, 1'b0));
      for (int i = 0; i < BL; i++) exp_wr_q.push_back(32'hB0 + 32'(i));
      for (int i = 0; i < BL; i++) exp_rd_q.push_back({2'b01, 32'hB8 + 32'(i)});
      fork
         do_req(2, 26'h180);
         do_req(1, 26'h280);
         begin
            mem_serve(0, 32'hB0, 16'hFFFF);
            mem_serve(0, 32'hB8, 16'hFFFF);
         end
      join
      repeat (2) @(negedge clk);

      // Write with m_wready stalls (beats on cycles 0,3,4,7); stray m_rvalid held high.
      m_rvalid = 1;
      m_rdata  = 32'h55;
      c0 = cyc;
      exp_gnt_q.push_back(gnt_rec(c0 + 1, 3'b100, 26'h600, 1'b1));
      for (int i = 0; i < BL; i++) exp_wr_q.push_back(32'h70 + 32'(i));
      fork
         do_req(2, 26'h600);
         mem_serve(0, 32'h70, 16'h0099);
      join
      #3;
      chk("stall_idle", 64'(dbg_state), 64'(IDLE));
      chk("stall_wr_left", 64'(exp_wr_q.size()), 64'd0);
      m_rvalid = 0;
      repeat (2) @(negedge clk);

      // ir waiting while dr keeps requesting.
`ifdef MEM_ARB_STARVE_GUARD_EN
      own = '{1, 1, 0, 1};
      adr = '{26'h200, 26'h210, 26'h300, 26'h220};
`else
      own = '{1, 1, 1, 0};
      adr = '{26'h200, 26'h210, 26'h220, 26'h300};
`endif
      c0 = cyc;
      for (int t = 0; t < 4; t++) begin
         exp_gnt_q.push_back(gnt_rec(c0 + 1 + 7 * t, (own[t] == 0) ? 3'b001 : 3'b010, adr[t], 1'b0));
         for (int i = 0; i < BL; i++)
            exp_rd_q.push_back({own[t] == 0, own[t] == 1, 32'hC0 + 32'(16 * t + i)});
      end
      fork
         do_req(0, 26'h300);
         begin
            do_req(1, 26'h200);
            do_req(1, 26'h210);
            do_req(1, 26'h220);
         end
         begin
            for (int t = 0; t < 4; t++) mem_serve(1, 32'hC0 + 32'(16 * t), 16'hFFFF);
         end
      join
      repeat (2) @(negedge clk);

      // Reset after 2 of 4 beats, with a dr request pending.
      c0 = cyc;
      exp_gnt_q.push_back(gnt_rec(c0 + 1, 3'b001, 26'h400, 1'b0));
      exp_rd_q.push_back({2'b10, 32'hD0});
      exp_rd_q.push_back({2'b10, 32'hD1});
      fork
         do_req(0, 26'h400);
         begin
            int t = 0;
            while (!m_req && t < 50) begin
               @(negedge clk);
               t++;
            end
            chk("m_req_seen", 64'(m_req), 64'd1);
            m_ack = 1;
            @(negedge clk);
            m_ack = 0;
            for (int i = 0; i < 2; i++) begin
               m_rvalid = 1;
               m_rdata  = 32'hD0 + 32'(i);
               @(negedge clk);
            end
            m_rvalid = 0;
         end
      join
      chk("pre_rst_state", 64'(dbg_state), 64'(RDATA));
      dr_addr = 26'h500;
      dr_req  = 1;
      #1;
      rst_n    = 0;
      m_rvalid = 1;
      m_rdata  = 32'hEE;
      m_wready = 1;
      #1;
      rst_checks("midrst");
      m_rvalid = 0;
      m_wready = 0;
      @(negedge clk);
      c1 = cyc;
      rst_n = 1;
      exp_gnt_q.push_back(gnt_rec(c1 + 1, 3'b010, 26'h500, 1'b0));
      for (int i = 0; i < BL; i++) exp_rd_q.push_back({2'b01, 32'hE0 + 32'(i)});
      fork
         do_req(1, 26'h500);
         mem_serve(1, 32'hE0, 16'hFFFF);
      join
      repeat (3) @(negedge clk);

      // ---------------- final report ----------------
      chk("gnt_q_left", 64'(exp_gnt_q.size()), 64'd0);
      chk("rd_q_left", 64'(exp_rd_q.size()), 64'd0);
      chk("wr_q_left", 64'(exp_wr_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
